// File: rtl/tjmono2_cmd_pkg.sv
// Shared definitions for the TJ-Monopix2 command receiver: frame constants,
// command enum, FSM states and the 8-bit symbol lookup tables.
package tjmono2_cmd_pkg;

  localparam logic [15:0] SYNC_FRAME     = 16'h817E;
  localparam logic [15:0] PLL_LOCK_FRAME = 16'hAAAA;

  typedef enum logic [2:0] {
    CMD_CLEAR        = 3'd0,
    CMD_GLOBAL_PULSE = 3'd1,
    CMD_CAL          = 3'd2,
    CMD_WRREG        = 3'd3,
    CMD_RDREG        = 3'd4,
    CMD_READ_TRIG    = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  // Returns {hit, value}.
  function automatic logic [5:0] data_sym_lookup(input logic [7:0] sym);
    logic [5:0] res;
    case (sym)
      8'h6A: res = {1'b1, 5'd0};
      8'h6C: res = {1'b1, 5'd1};
      8'h71: res = {1'b1, 5'd2};
      8'h72: res = {1'b1, 5'd3};
      8'h74: res = {1'b1, 5'd4};
      8'h8B: res = {1'b1, 5'd5};
      8'h8D: res = {1'b1, 5'd6};
      8'h8E: res = {1'b1, 5'd7};
      8'h93: res = {1'b1, 5'd8};
      8'h95: res = {1'b1, 5'd9};
      8'h96: res = {1'b1, 5'd10};
      8'h99: res = {1'b1, 5'd11};
      8'h9A: res = {1'b1, 5'd12};
      8'h9C: res = {1'b1, 5'd13};
      8'hA3: res = {1'b1, 5'd14};
      8'hA5: res = {1'b1, 5'd15};
      8'hA6: res = {1'b1, 5'd16};
      8'hA9: res = {1'b1, 5'd17};
      8'h59: res = {1'b1, 5'd18};
      8'hAC: res = {1'b1, 5'd19};
      8'hB1: res = {1'b1, 5'd20};
      8'hB2: res = {1'b1, 5'd21};
      8'hB4: res = {1'b1, 5'd22};
      8'hC3: res = {1'b1, 5'd23};
      8'hC5: res = {1'b1, 5'd24};
      8'hC6: res = {1'b1, 5'd25};
      8'hC9: res = {1'b1, 5'd26};
      8'hCA: res = {1'b1, 5'd27};
      8'hCC: res = {1'b1, 5'd28};
      8'hD1: res = {1'b1, 5'd29};
      8'hD2: res = {1'b1, 5'd30};
      8'hD4: res = {1'b1, 5'd31};
      default: res = 6'd0;
    endcase
    return res;
  endfunction

  // Returns {hit, bunch pattern}; bit3 of the pattern is the earliest bunch.
  function automatic logic [4:0] trig_sym_lookup(input logic [7:0] sym);
    logic [4:0] res;
    case (sym)
      8'h2B: res = {1'b1, 4'b0001};
      8'h2D: res = {1'b1, 4'b0010};
      8'h2E: res = {1'b1, 4'b0011};
      8'h33: res = {1'b1, 4'b0100};
      8'h35: res = {1'b1, 4'b0101};
      8'h36: res = {1'b1, 4'b0110};
      8'h39: res = {1'b1, 4'b0111};
      8'h3A: res = {1'b1, 4'b1000};
      8'h3C: res = {1'b1, 4'b1001};
      8'h4B: res = {1'b1, 4'b1010};
      8'h4D: res = {1'b1, 4'b1011};
      8'h4E: res = {1'b1, 4'b1100};
      8'h53: res = {1'b1, 4'b1101};
      8'h55: res = {1'b1, 4'b1110};
      8'h56: res = {1'b1, 4'b1111};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

  // Returns {hit, command code}.
  function automatic logic [3:0] hdr_sym_lookup(input logic [7:0] sym);
    logic [3:0] res;
    case (sym)
      8'h5A: res = {1'b1, CMD_CLEAR};
      8'h5C: res = {1'b1, CMD_GLOBAL_PULSE};
      8'h63: res = {1'b1, CMD_CAL};
      8'h66: res = {1'b1, CMD_WRREG};
      8'h65: res = {1'b1, CMD_RDREG};
      8'h69: res = {1'b1, CMD_READ_TRIG};
      default: res = 4'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tjmono2_cmd_sym_dec.sv
// Combinational classifier for one 8-bit command symbol.
module tjmono2_cmd_sym_dec
  import tjmono2_cmd_pkg::*;
(
  input  logic [7:0] sym,
  output logic       is_data,
  output logic       is_trig,
  output logic       is_hdr,
  output logic [4:0] value,
  output logic [3:0] pattern,
  output cmd_e       code
);

  logic [5:0] data_hit_s;
  logic [4:0] trig_hit_s;
  logic [3:0] hdr_hit_s;

  // Table lookups and field split.
  always_comb begin
    data_hit_s = data_sym_lookup(sym);
    trig_hit_s = trig_sym_lookup(sym);
    hdr_hit_s  = hdr_sym_lookup(sym);
    is_data    = data_hit_s[5];
    value      = data_hit_s[4:0];
    is_trig    = trig_hit_s[4];
    pattern    = trig_hit_s[3:0];
    is_hdr     = hdr_hit_s[3];
    code       = cmd_e'(hdr_hit_s[2:0]);
  end

endmodule

// File: rtl/tjmono2_cmd_rx.sv
// Serial command receiver: deserialises CMD, aligns to 16-bit frames on the
// sync word and decodes trigger, command-header and data frames into pulses.
module tjmono2_cmd_rx
  import tjmono2_cmd_pkg::*;
#(
  parameter int unsigned SYNC_LOCK_COUNT  = 8,
  parameter int unsigned UNLOCK_ERR_COUNT = 4
) (
  input  logic       CMD_CLK,
  input  logic       RSTB,
  input  logic       CMD_SERIAL_IN,
  input  logic       ERR_CNT_CLR,
  output logic       LOCKED,
  output logic       TRIG_VALID,
  output logic [3:0] TRIG_PATTERN,
  output logic [4:0] TRIG_TAG,
  output logic       CMD_VALID,
  output logic [2:0] CMD_CODE,
  output logic [4:0] CMD_CHIP_ID,
  output logic       DATA_VALID,
  output logic [9:0] DATA,
  output logic       SYMBOL_ERR,
  output logic [7:0] ERR_CNT
);

  localparam logic [7:0] LOCK_CNT_C   = 8'(SYNC_LOCK_COUNT);
  localparam logic [7:0] UNLOCK_CNT_C = 8'(UNLOCK_ERR_COUNT);

  // phase_r is the frame position of the bit most recently shifted in.
  logic [15:0] sreg_r;
  logic [3:0]  phase_r, phase_s;
  logic [7:0]  sync_cnt_r, sync_cnt_s;
  logic [7:0]  miss_cnt_r, miss_cnt_s;
  rx_state_e   state_r, state_s;
  logic        locked_s, trig_s, cmd_s, data_s, err_s;
  logic        frame_end_s;

  logic        hi_is_data_s, hi_is_trig_s, hi_is_hdr_s;
  logic [4:0]  hi_value_s;
  logic [3:0]  hi_pattern_s;
  cmd_e        hi_code_s;
  logic        lo_is_data_s, lo_is_trig_s, lo_is_hdr_s;
  logic [4:0]  lo_value_s;
  logic [3:0]  lo_pattern_s;
  cmd_e        lo_code_s;
  logic        lo_unused_s;

  tjmono2_cmd_sym_dec u_dec_hi (
    .sym     (sreg_r[15:8]),
    .is_data (hi_is_data_s),
    .is_trig (hi_is_trig_s),
    .is_hdr  (hi_is_hdr_s),
    .value   (hi_value_s),
    .pattern (hi_pattern_s),
    .code    (hi_code_s)
  );

  tjmono2_cmd_sym_dec u_dec_lo (
    .sym     (sreg_r[7:0]),
    .is_data (lo_is_data_s),
    .is_trig (lo_is_trig_s),
    .is_hdr  (lo_is_hdr_s),
    .value   (lo_value_s),
    .pattern (lo_pattern_s),
    .code    (lo_code_s)
  );

  // Only the data value of the lo symbol carries meaning.
  assign lo_unused_s = ^{lo_is_trig_s, lo_is_hdr_s, lo_pattern_s, lo_code_s};
  assign frame_end_s = (phase_r == 4'd15);

  // Deserialiser, phase counter and FSM state registers.
  always_ff @(posedge CMD_CLK or negedge RSTB) begin
    if (!RSTB) begin
      sreg_r     <= 16'd0;
      phase_r    <= 4'd0;
      sync_cnt_r <= 8'd0;
      miss_cnt_r <= 8'd0;
      state_r    <= ST_SEARCH;
    end else begin
      sreg_r     <= {sreg_r[14:0], CMD_SERIAL_IN};
      phase_r    <= phase_s;
      sync_cnt_r <= sync_cnt_s;
      miss_cnt_r <= miss_cnt_s;
      state_r    <= state_s;
    end
  end

  // Alignment / decode FSM: next state, counters and event decisions.
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r + 4'd1;
    sync_cnt_s = sync_cnt_r;
    miss_cnt_s = miss_cnt_r;
    locked_s   = LOCKED;
    trig_s     = 1'b0;
    cmd_s      = 1'b0;
    data_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        if (sreg_r == SYNC_FRAME) begin
          // Next incoming bit is the first bit of a frame.
          phase_s    = 4'd0;
          sync_cnt_s = 8'd1;
          miss_cnt_s = 8'd0;
          if (LOCK_CNT_C == 8'd1) begin
            state_s  = ST_LOCKED;
            locked_s = 1'b1;
          end else begin
            state_s  = ST_ALIGN;
          end
        end else begin
          sync_cnt_s = 8'd0;
        end
      end
      ST_ALIGN: begin
        if (frame_end_s) begin
          if (sreg_r == SYNC_FRAME) begin
            sync_cnt_s = sync_cnt_r + 8'd1;
            if (sync_cnt_s == LOCK_CNT_C) begin
              state_s    = ST_LOCKED;
              locked_s   = 1'b1;
              miss_cnt_s = 8'd0;
            end else begin
              state_s    = ST_ALIGN;
            end
          end else begin
            state_s    = ST_SEARCH;
            sync_cnt_s = 8'd0;
          end
        end else begin
          state_s = ST_ALIGN;
        end
      end
      ST_LOCKED: begin
        if (frame_end_s) begin
          if ((sreg_r == SYNC_FRAME) || (sreg_r == PLL_LOCK_FRAME)) begin
            miss_cnt_s = 8'd0;
          end else if (hi_is_trig_s && lo_is_data_s) begin
            trig_s     = 1'b1;
            miss_cnt_s = 8'd0;
          end else if (hi_is_hdr_s && lo_is_data_s) begin
            cmd_s      = 1'b1;
            miss_cnt_s = 8'd0;
          end else if (hi_is_data_s && lo_is_data_s) begin
            data_s     = 1'b1;
            miss_cnt_s = 8'd0;
          end else begin
            err_s      = 1'b1;
            miss_cnt_s = miss_cnt_r + 8'd1;
            if (miss_cnt_s == UNLOCK_CNT_C) begin
              state_s    = ST_SEARCH;
              locked_s   = 1'b0;
              sync_cnt_s = 8'd0;
              miss_cnt_s = 8'd0;
            end else begin
              state_s    = ST_LOCKED;
            end
          end
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s    = ST_SEARCH;
        locked_s   = 1'b0;
        sync_cnt_s = 8'd0;
        miss_cnt_s = 8'd0;
      end
    endcase
  end

  // Registered event pulses, held payloads and the saturating error counter.
  always_ff @(posedge CMD_CLK or negedge RSTB) begin
    if (!RSTB) begin
      LOCKED       <= 1'b0;
      TRIG_VALID   <= 1'b0;
      TRIG_PATTERN <= 4'd0;
      TRIG_TAG     <= 5'd0;
      CMD_VALID    <= 1'b0;
      CMD_CODE     <= 3'd0;
      CMD_CHIP_ID  <= 5'd0;
      DATA_VALID   <= 1'b0;
      DATA         <= 10'd0;
      SYMBOL_ERR   <= 1'b0;
      ERR_CNT      <= 8'd0;
    end else begin
      LOCKED     <= locked_s;
      TRIG_VALID <= trig_s;
      CMD_VALID  <= cmd_s;
      DATA_VALID <= data_s;
      SYMBOL_ERR <= err_s;
      if (trig_s) begin
        TRIG_PATTERN <= hi_pattern_s;
        TRIG_TAG     <= lo_value_s;
      end
      if (cmd_s) begin
        CMD_CODE    <= hi_code_s;
        CMD_CHIP_ID <= lo_value_s;
      end
      if (data_s) begin
        DATA <= {hi_value_s, lo_value_s};
      end
      if (ERR_CNT_CLR) begin
        ERR_CNT <= 8'd0;
      end else if (err_s && (ERR_CNT != 8'hFF)) begin
        ERR_CNT <= ERR_CNT + 8'd1;
      end
    end
  end

endmodule
